// File: rtl/up_tpl_adc_pn_stats_pkg.sv
// Shared definitions for the TPL ADC PN-monitor statistics bank.
// It holds the register offsets within the page, the CONTROL bit indices,
// the VERSION readback value, and the control bundle that the top sends to
// every channel.
package up_tpl_adc_pn_stats_pkg;

    // Register offsets (low byte of the word address)
    localparam logic [7:0] REG_VERSION    = 8'h00;
    localparam logic [7:0] REG_CONTROL    = 8'h01;
    localparam logic [7:0] REG_STICKY_ERR = 8'h02;
    localparam logic [7:0] REG_STICKY_OOS = 8'h03;
    localparam logic [7:0] REG_IRQ_MASK   = 8'h04;
    localparam logic [7:0] REG_SNAP_BASE  = 8'h10;

    // CONTROL register bit positions
    localparam int CTRL_COUNT_EN  = 0;
    localparam int CTRL_SNAPSHOT  = 1;
    localparam int CTRL_CLEAR_ALL = 2;

    localparam logic [31:0] VERSION_VALUE = 32'h0001_0061;

    // Control broadcast from the register block to every channel.
    // snapshot and clear_all are single-cycle strobes.
    typedef struct packed {
        logic count_en;
        logic snapshot;
        logic clear_all;
    } chan_ctrl_t;

endpackage

// File: rtl/up_tpl_adc_pn_stats_channel.sv
// One channel of the PN statistics bank. The top generates one instance per
// channel.
//
// Contents:
//   - pn_oos rising-edge detector
//   - saturating live/snapshot counters for error cycles and OOS events
//   - sticky_err / sticky_oos status bits
//
// Ports:
//   up_clk, up_rstn    clock and asynchronous active-low reset
//   pn_err, pn_oos     PN monitor levels, already in the up_clk domain
//   ctrl               count_en level plus the snapshot/clear_all strobes
//   w1c_err, w1c_oos   write-one-to-clear strobes for the sticky bits
//   err_snap, oos_snap snapshot counter values
//   sticky_err/oos     sticky status bits
module up_tpl_adc_pn_stats_channel
    import up_tpl_adc_pn_stats_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     pn_err,
    input  logic                     pn_oos,
    input  chan_ctrl_t               ctrl,
    input  logic                     w1c_err,
    input  logic                     w1c_oos,
    output logic [COUNTER_WIDTH-1:0] err_snap,
    output logic [COUNTER_WIDTH-1:0] oos_snap,
    output logic                     sticky_err,
    output logic                     sticky_oos
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic                     oos_prev_reg;
    logic [COUNTER_WIDTH-1:0] err_live_reg, err_live_next;
    logic [COUNTER_WIDTH-1:0] oos_live_reg, oos_live_next;
    logic [COUNTER_WIDTH-1:0] err_snap_reg, err_snap_next;
    logic [COUNTER_WIDTH-1:0] oos_snap_reg, oos_snap_next;
    logic                     sticky_err_reg, sticky_err_next;
    logic                     sticky_oos_reg, sticky_oos_next;

    logic err_hit;
    logic err_inc;
    logic oos_rise;

    // While out of sync, error indications are meaningless and are ignored.
    assign err_hit  = pn_err & ~pn_oos;
    assign err_inc  = ctrl.count_en & err_hit;
    // Loss-of-lock events are counted even while counting is disabled.
    assign oos_rise = pn_oos & ~oos_prev_reg;

    always_comb begin
        err_live_next   = err_live_reg;
        oos_live_next   = oos_live_reg;
        err_snap_next   = err_snap_reg;
        oos_snap_next   = oos_snap_reg;
        sticky_err_next = sticky_err_reg;
        sticky_oos_next = sticky_oos_reg;

        if (ctrl.clear_all) begin
            // clear_all overrides everything: increments, sticky sets, snapshot
            err_live_next   = '0;
            oos_live_next   = '0;
            err_snap_next   = '0;
            oos_snap_next   = '0;
            sticky_err_next = 1'b0;
            sticky_oos_next = 1'b0;
        end else begin
            if (ctrl.snapshot) begin
                // A coincident event is carried into the fresh live count so
                // that nothing is lost across the snapshot boundary.
                err_snap_next = err_live_reg;
                oos_snap_next = oos_live_reg;
                err_live_next = err_inc  ? CNT_ONE : '0;
                oos_live_next = oos_rise ? CNT_ONE : '0;
            end else begin
                if (err_inc && (err_live_reg != CNT_MAX))
                    err_live_next = err_live_reg + CNT_ONE;
                if (oos_rise && (oos_live_reg != CNT_MAX))
                    oos_live_next = oos_live_reg + CNT_ONE;
            end

            // A set takes priority over a simultaneous W1C.
            if (err_hit)
                sticky_err_next = 1'b1;
            else if (w1c_err)
                sticky_err_next = 1'b0;

            if (oos_rise)
                sticky_oos_next = 1'b1;
            else if (w1c_oos)
                sticky_oos_next = 1'b0;
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            oos_prev_reg   <= 1'b0;
            err_live_reg   <= '0;
            oos_live_reg   <= '0;
            err_snap_reg   <= '0;
            oos_snap_reg   <= '0;
            sticky_err_reg <= 1'b0;
            sticky_oos_reg <= 1'b0;
        end else begin
            oos_prev_reg   <= pn_oos;
            err_live_reg   <= err_live_next;
            oos_live_reg   <= oos_live_next;
            err_snap_reg   <= err_snap_next;
            oos_snap_reg   <= oos_snap_next;
            sticky_err_reg <= sticky_err_next;
            sticky_oos_reg <= sticky_oos_next;
        end
    end

    assign err_snap   = err_snap_reg;
    assign oos_snap   = oos_snap_reg;
    assign sticky_err = sticky_err_reg;
    assign sticky_oos = sticky_oos_reg;

endmodule

// File: rtl/up_tpl_adc_pn_stats.sv
// PN-monitor statistics bank for the JESD204 TPL ADC register map.
// It sits on the up_wreq/up_rreq bus as one more slave whose rdata/acks are
// OR-combined upstream, so it drives zeros whenever it is not acking.
//
// Ports:
//   up_clk, up_rstn            bus/counting clock and async active-low reset
//   pn_err, pn_oos             per-channel PN monitor levels (up_clk domain)
//   up_wreq/up_waddr/up_wdata  write request, one-cycle pulse
//   up_wack                    write acknowledge, one cycle after the request
//   up_rreq/up_raddr           read request, one-cycle pulse
//   up_rdata/up_rack           registered read data and acknowledge
//   up_irq                     level interrupt: masked OR of the sticky bits
module up_tpl_adc_pn_stats
    import up_tpl_adc_pn_stats_pkg::*;
#(
    parameter int          NUM_CHANNELS  = 4,
    parameter int          COUNTER_WIDTH = 16,
    parameter logic [5:0]  COMMON_ID     = 6'h3
) (
    input  logic                    up_clk,
    input  logic                    up_rstn,
    input  logic [NUM_CHANNELS-1:0] pn_err,
    input  logic [NUM_CHANNELS-1:0] pn_oos,
    input  logic                    up_wreq,
    input  logic [13:0]             up_waddr,
    input  logic [31:0]             up_wdata,
    output logic                    up_wack,
    input  logic                    up_rreq,
    input  logic [13:0]             up_raddr,
    output logic [31:0]             up_rdata,
    output logic                    up_rack,
    output logic                    up_irq
);

    logic                    wr_sel;
    logic                    rd_sel;
    logic [7:0]              wr_off;
    logic [7:0]              rd_off;
    logic [7:0]              snap_idx;
    logic                    wr_control;

    logic                    count_en_reg;
    logic [NUM_CHANNELS-1:0] irq_mask_reg;
    logic                    wack_reg;
    logic                    rack_reg;
    logic [31:0]             rdata_reg, rdata_next;
    logic                    irq_reg;

    chan_ctrl_t              chan_ctrl;
    logic [NUM_CHANNELS-1:0] w1c_err_vec;
    logic [NUM_CHANNELS-1:0] w1c_oos_vec;
    logic [NUM_CHANNELS-1:0] sticky_err_vec;
    logic [NUM_CHANNELS-1:0] sticky_oos_vec;
    logic [COUNTER_WIDTH-1:0] err_snap_arr [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] oos_snap_arr [NUM_CHANNELS];

    // Not every write-data bit maps to a register field.
    logic unused_wdata;
    assign unused_wdata = ^up_wdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign wr_sel     = up_wreq && (up_waddr[13:8] == COMMON_ID);
    assign rd_sel     = up_rreq && (up_raddr[13:8] == COMMON_ID);
    assign wr_off     = up_waddr[7:0];
    assign rd_off     = up_raddr[7:0];
    assign wr_control = wr_sel && (wr_off == REG_CONTROL);

    // clear_all dominates, so writing snapshot and clear together is a clear.
    assign chan_ctrl.count_en  = count_en_reg;
    assign chan_ctrl.clear_all = wr_control & up_wdata[CTRL_CLEAR_ALL];
    assign chan_ctrl.snapshot  = wr_control & up_wdata[CTRL_SNAPSHOT]
                                            & ~up_wdata[CTRL_CLEAR_ALL];

    assign w1c_err_vec = (wr_sel && (wr_off == REG_STICKY_ERR)) ?
                         up_wdata[NUM_CHANNELS-1:0] : '0;
    assign w1c_oos_vec = (wr_sel && (wr_off == REG_STICKY_OOS)) ?
                         up_wdata[NUM_CHANNELS-1:0] : '0;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        up_tpl_adc_pn_stats_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_chan (
            .up_clk     (up_clk),
            .up_rstn    (up_rstn),
            .pn_err     (pn_err[gi]),
            .pn_oos     (pn_oos[gi]),
            .ctrl       (chan_ctrl),
            .w1c_err    (w1c_err_vec[gi]),
            .w1c_oos    (w1c_oos_vec[gi]),
            .err_snap   (err_snap_arr[gi]),
            .oos_snap   (oos_snap_arr[gi]),
            .sticky_err (sticky_err_vec[gi]),
            .sticky_oos (sticky_oos_vec[gi])
        );
    end

    // ------------------------------------------------------------------
    // Readback mux
    // ------------------------------------------------------------------
    // Snapshot registers are interleaved: even offsets give the error count,
    // odd offsets give the OOS count. Offsets below SNAP_BASE wrap to large
    // values and never match a channel index.
    assign snap_idx = rd_off - REG_SNAP_BASE;

    always_comb begin
        rdata_next = '0;
        if (rd_sel) begin
            case (rd_off)
                REG_VERSION:    rdata_next = VERSION_VALUE;
                REG_CONTROL:    rdata_next = {31'd0, count_en_reg};
                REG_STICKY_ERR: rdata_next = 32'(sticky_err_vec);
                REG_STICKY_OOS: rdata_next = 32'(sticky_oos_vec);
                REG_IRQ_MASK:   rdata_next = 32'(irq_mask_reg);
                default: begin
                    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                        if (snap_idx[7:1] == 7'(ch))
                            rdata_next = snap_idx[0] ? 32'(oos_snap_arr[ch])
                                                     : 32'(err_snap_arr[ch]);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers, acks and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            count_en_reg <= 1'b1;
            irq_mask_reg <= '0;
            wack_reg     <= 1'b0;
            rack_reg     <= 1'b0;
            rdata_reg    <= '0;
            irq_reg      <= 1'b0;
        end else begin
            wack_reg  <= wr_sel;
            rack_reg  <= rd_sel;
            rdata_reg <= rdata_next;
            if (wr_control)
                count_en_reg <= up_wdata[CTRL_COUNT_EN];
            if (wr_sel && (wr_off == REG_IRQ_MASK))
                irq_mask_reg <= up_wdata[NUM_CHANNELS-1:0];
            irq_reg <= |((sticky_err_vec | sticky_oos_vec) & irq_mask_reg);
        end
    end

    assign up_wack  = wack_reg;
    assign up_rack  = rack_reg;
    assign up_rdata = rdata_reg;
    assign up_irq   = irq_reg;

endmodule
